// File: rtl/fifo_write_arbiter_if.sv
// ============================================================================
// fifo_write_arbiter_if
//   Bundle of the requester-side and FIFO-write-side signals of the
//   round-robin FIFO write arbiter.
//
//   Signals:
//     req      NUM_REQ             per-requester request (held with data until granted)
//     req_data NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//     full     1                   FIFO full flag (write domain)
//     gnt      NUM_REQ             one-hot accept strobe
//     w_en     1                   FIFO write enable
//     w_data   DATA_WIDTH          FIFO data_in
//     owner    ID_WIDTH            current grant owner
//     busy     1                   high while a grant is active
//
//   Modports:
//     master : requesters + FIFO side (drives req/req_data/full)
//     slave  : the arbiter (drives gnt/w_en/w_data/owner/busy)
// ============================================================================
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [ID_WIDTH-1:0]           owner;
    logic                          busy;

    modport master (
        output req,
        output req_data,
        output full,
        input  gnt,
        input  w_en,
        input  w_data,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  full,
        output gnt,
        output w_en,
        output w_data,
        output owner,
        output busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// fifo_write_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters
//   in the FIFO write-clock domain. A grant lasts for up to MAX_BURST accepted
//   words; the arbiter writes the owner's word straight into the FIFO in the
//   same cycle it accepts it, and stalls (without releasing) while full=1.
//
//   Ports:
//     i_clk      write-domain clock (FIFO w_clk)
//     i_rst      synchronous, active-high reset
//     bus        fifo_write_arbiter_if.slave (req/req_data/full in,
//                gnt/w_en/w_data/owner/busy out)
//     o_word_cnt accepted-word counter, present only with WR_ARB_CNT_EN
//
//   Build option:
//     WR_ARB_CNT_EN  when defined, adds CNT_WIDTH parameter, the o_word_cnt
//                    port and its wrapping counter.
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = 2
`ifdef WR_ARB_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fifo_write_arbiter_if.slave   bus
`ifdef WR_ARB_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_word_cnt
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Burst counter only needs to hold 0..MAX_BURST-1.
    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // First requester at or after ptr+1 (wrapping); the pointer itself is
    // checked last, so a sole requester is re-picked.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [NUM_REQ-1:0]  reqs,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic [ID_WIDTH-1:0] pick;
        logic                found;
        int                  idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && reqs[idx]) begin
                pick  = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [0:0]          r_st;
    logic [ID_WIDTH-1:0] r_owner;
    logic [ID_WIDTH-1:0] r_last;
    logic [BCNT_W-1:0]   r_bcnt;

    logic [0:0]          w_st_nxt;
    logic [ID_WIDTH-1:0] w_owner_nxt;
    logic [ID_WIDTH-1:0] w_last_nxt;
    logic [BCNT_W-1:0]   w_bcnt_nxt;
    logic                w_release;
    logic                w_any_req;
    logic                w_own_req;
    logic                w_last_beat;
    logic                w_xfer;

    assign w_any_req   = |bus.req;
    assign w_own_req   = bus.req[r_owner];
    assign w_last_beat = (r_bcnt == BCNT_W'(MAX_BURST - 1));

    // Accept path is combinational from the registered owner so the FIFO
    // write lands in the same cycle as the accept, with full seen live.
    assign w_xfer     = (r_st == ST_GRANT) & w_own_req & ~bus.full;
    assign bus.w_en   = w_xfer;
    assign bus.gnt    = w_xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner) : {NUM_REQ{1'b0}};
    assign bus.w_data = bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign bus.owner  = r_owner;
    assign bus.busy   = (r_st == ST_GRANT);

    // Next-state logic: arbitration in IDLE, burst/stall/release in GRANT.
    always_comb begin
        w_st_nxt    = r_st;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        w_release   = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = rr_pick(bus.req, r_last);
                    w_last_nxt  = rr_pick(bus.req, r_last);
                    w_bcnt_nxt  = {BCNT_W{1'b0}};
                    w_st_nxt    = ST_GRANT;
                end else begin
                    w_st_nxt    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    w_release = 1'b1;
                end else if (bus.full) begin
                    // Stall: the grant is never released because of full.
                    w_bcnt_nxt = r_bcnt;
                end else if (w_last_beat) begin
                    w_release = 1'b1;
                end else begin
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                end
            end
            default: begin
                w_st_nxt = ST_IDLE;
            end
        endcase

        // Release hands straight over to the next requester (no idle bubble).
        if (w_release) begin
            w_last_nxt = r_owner;
            w_bcnt_nxt = {BCNT_W{1'b0}};
            if (w_any_req) begin
                w_owner_nxt = rr_pick(bus.req, r_owner);
                w_st_nxt    = ST_GRANT;
            end else begin
                w_st_nxt    = ST_IDLE;
            end
        end else begin
            w_last_nxt = w_last_nxt;
        end
    end

    // State registers with synchronous reset; reset mid-burst simply aborts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st    <= ST_IDLE;
            r_owner <= {ID_WIDTH{1'b0}};
            r_last  <= ID_WIDTH'(NUM_REQ - 1);
            r_bcnt  <= {BCNT_W{1'b0}};
        end else begin
            r_st    <= w_st_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

`ifdef WR_ARB_CNT_EN
    logic [CNT_WIDTH-1:0] r_word_cnt;

    // Accepted-word counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end else begin
            r_word_cnt <= r_word_cnt;
        end
    end

    assign o_word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// tb_fifo_write_arbiter
//   Self-checking bench: a cycle-by-cycle vector table for reset, single
//   requester, full stall, early drop and mid-burst reset, then a scoreboarded
//   fairness run with all four requesters active (and the word counter when
//   WR_ARB_CNT_EN is defined).
// ============================================================================
module tb_fifo_write_arbiter;

    logic clk;
    logic rst;

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) bus ();

`ifdef WR_ARB_CNT_EN
    logic [15:0] word_cnt;
`endif

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4),
        .ID_WIDTH   (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus.slave)
`ifdef WR_ARB_CNT_EN
        ,
        .o_word_cnt (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       w_en;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    logic [7:0] dval [4];

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic f,
                       input logic [3:0] g, input logic we, input logic [1:0] ow, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f;
        v.gnt = g; v.w_en = we; v.owner = ow; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   wcnt17;

        checks   = 0;
        failures = 0;
        dval[0] = 8'h11; dval[1] = 8'h22; dval[2] = 8'h33; dval[3] = 8'h44;

        // ---- vector table ----
        // reset with all requests pending
        add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        // single requester 2: arbitration cycle, 4 writes, re-pick without bubble
        add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
        // drop -> release to IDLE
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1);
        // owner 1, two words, then full stall for 5 cycles
        add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) add(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1);
        // exactly two more words, then handover to 0
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        // owner 0 drops -> owner 3; owner 3 drops after one word -> owner 0 (wrap)
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
        add(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        // mid-burst reset
        add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
        add(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
        add(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        // initial reset edge
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.full = 1'b0;
        bus.req_data = {dval[3], dval[2], dval[1], dval[0]};
        @(posedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst      = vecs[r].rst;
            bus.req  = vecs[r].req;
            bus.full = vecs[r].full;
            #1;
            chk($sformatf("row%0d_gnt", r),   32'(bus.gnt),   32'(vecs[r].gnt));
            chk($sformatf("row%0d_w_en", r),  32'(bus.w_en),  32'(vecs[r].w_en));
            chk($sformatf("row%0d_owner", r), 32'(bus.owner), 32'(vecs[r].owner));
            chk($sformatf("row%0d_busy", r),  32'(bus.busy),  32'(vecs[r].busy));
            if (vecs[r].w_en) begin
                chk($sformatf("row%0d_w_data", r), 32'(bus.w_data), 32'(dval[vecs[r].owner]));
            end
        end

        // ---- fairness run with scoreboard: 37 words, owners 0,1,2,3,0,... ----
        for (int k = 0; k < 37; k++) begin
            e.owner = 2'((k / 4) % 4);
            e.data  = dval[(k / 4) % 4];
            sb_q.push_back(e);
        end
        cyc    = 0;
        wcnt17 = 0;
        while (sb_q.size() != 0 && cyc < 60) begin
            @(negedge clk);
            rst      = 1'b0;
            bus.req  = 4'b1111;
            bus.full = 1'b0;
            #1;
            if (cyc == 0) begin
                chk("fair_arb_cycle_w_en", 32'(bus.w_en), 32'd0);
`ifdef WR_ARB_CNT_EN
                chk("cnt_after_reset", 32'(word_cnt), 32'd0);
`endif
            end
            if (bus.w_en) begin
                if (cyc < 17) wcnt17++;
                e = sb_q.pop_front();
                chk($sformatf("fair%0d_owner", cyc), 32'(bus.owner), 32'(e.owner));
                chk($sformatf("fair%0d_gnt", cyc),   32'(bus.gnt),   32'(4'b0001 << e.owner));
                chk($sformatf("fair%0d_data", cyc),  32'(bus.w_data), 32'(e.data));
            end
            cyc++;
        end
        chk("fair_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("fair_16_words_in_17", 32'(wcnt17), 32'd16);

        @(negedge clk);
        bus.req = 4'b0000;
        #1;
`ifdef WR_ARB_CNT_EN
        chk("cnt_37", 32'(word_cnt), 32'd37);
`endif
        chk("fair_end_w_en", 32'(bus.w_en), 32'd0);

        // reset after the run
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_owner", 32'(bus.owner), 32'd0);
`ifdef WR_ARB_CNT_EN
        chk("post_rst_cnt", 32'(word_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
